alu_serial: RTL and testbench
=============================

# alu_serial

Parametrised multi-bit ALU that evaluates a `WIDTH`-bit operation bit-serially, LSB first, one bit per clock. Each cycle it applies the existing 1-bit ALU function (ADD/SUB/AND/OR/NOR/XOR with a registered carry) to one bit. Operands are captured on a start handshake. The block returns a full-width result plus zero, negative and overflow flags with a single-cycle done pulse. It sits next to the combinational ALU in the datapath, for area-constrained multi-cycle configurations.

## Interface
- `WIDTH`, default 32, operand/result width in bits; legal range is WIDTH ≥ 2.
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only while idle.
- `A`  in  WIDTH  operand A; captured on an accepted start.
- `B`  in  WIDTH  operand B; captured on an accepted start.
- `control`  in  3  operation; captured on an accepted start. Encoding: 2 ADD, 3 SUB, 4 AND, 5 OR, 6 NOR, 7 XOR; 0 and 1 are reserved.
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  one-cycle pulse when a result becomes valid.
- `out`  out  WIDTH  result; held stable between done pulses.
- `zero`  out  1  out == 0.
- `negative`  out  1  out[WIDTH-1].
- `overflow`  out  1  signed overflow for ADD/SUB; 0 for all other ops.

## Operation
- States:
  - IDLE: busy=0.
  - RUN: busy=1, bit counter `k` runs 0..WIDTH-1.
  - IDLE is re-entered with a done pulse.
- Transitions:
  - IDLE + start=1 → RUN. Latch A, B and control; set k=0.
  - Carry register initialises to 1 for SUB, 0 otherwise.
  - IDLE + start=0 → IDLE.
- Each RUN cycle computes bit k from a=A[k], b=B[k] (b inverted for SUB) and the carry register:
  - ADD/SUB: sum = a^b^c; carry register ← carry-out.
  - AND/OR/NOR/XOR: bitwise on a and b (uninverted B); carry register unused.
  - Reserved codes: result bit 0.
- Result bit k is shifted into an internal result shift register. `out` is not modified during RUN.
- On the RUN cycle with k = WIDTH-1:
  - Copy the completed result to `out` and update the flags at the same edge.
  - Return to IDLE and assert done for exactly the following cycle.
- Overflow is carry-into-MSB XOR carry-out-of-MSB (equivalently, sign rule on A, B' and the result). Only ADD/SUB can set it.
- zero and negative are derived from the registered `out`, so they are always consistent with it.
- A start during RUN is ignored; latched operands and control are unaffected.
- A start in the done cycle is legal (the block is IDLE) and is accepted.
- Arithmetic is modulo 2^WIDTH; carry-out is not exported.

## Timing
- Latency: start sampled at edge E0. Bit 0 is computed at E1 and bit WIDTH-1 at E_WIDTH.
- busy is high in cycles E0..E_WIDTH (WIDTH cycles).
- done is high in the single cycle after E_WIDTH; out and flags are valid from that cycle.
- Throughput is one operation per WIDTH+1 cycles with back-to-back starts: a start held high continuously re-launches on each done cycle.
- out and flags hold their last value indefinitely until the next completion.
- Reset (any state, including mid-RUN):
  - Next cycle: state IDLE, busy=0, done=0, out=0, zero=1, negative=0, overflow=0.
  - An in-flight operation is discarded with no done pulse.
  - Reset has priority over start in the same cycle.
- A, B and control may change freely after the accepted-start edge.

## Test plan
- WIDTH=8, ADD A=0x05 B=0x03 → done exactly 9 cycles after the start edge (busy 8 cycles), out=0x08, zero=0, negative=0, overflow=0.
- WIDTH=8 signed boundaries:
  - SUB A=0x80 B=0x01 → out=0x7F, overflow=1.
  - ADD 0x7F+0x01 → out=0x80, negative=1, overflow=1.
  - SUB 0x03-0x03 → out=0x00, zero=1, overflow=0.
- WIDTH=8 logic ops, A=0xCA B=0x5C:
  - AND → 0x48.
  - OR → 0xDE.
  - NOR → 0x21.
  - XOR → 0x96.
  - overflow=0 on each.
  - Reserved code 0 → out=0x00, zero=1.
- Start pulsed mid-RUN with different A/B → ignored. The original result is delivered on schedule, then the block returns to IDLE with no extra done pulse.
- Reset asserted 4 cycles into a RUN → next cycle busy=0, out=0, zero=1. No done pulse follows. A new ADD 0x01+0x01 → 0x02.
- start held high continuously, ADD 0xFF+0x01 then SUB 0x00-0x01 → done pulses 9 cycles apart. Results 0x00 (zero=1, overflow=0) then 0xFF (negative=1, overflow=0). Repeat at WIDTH=32: 0xFFFFFFFF+1 → 0, done after 33 cycles.

Source files
------------

// File: rtl/alu_serial.sv
// Bit-serial ALU: evaluates a WIDTH-bit ADD/SUB/AND/OR/NOR/XOR one bit per clock, LSB first,
// and publishes the full result with zero/negative/overflow flags and a one-cycle done pulse.
module alu_serial #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       control,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             negative,
    output logic             overflow
);

    localparam int              KW     = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [KW-1:0]   K_LAST = KW'(WIDTH - 1);

    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_NOR = 3'd6;
    localparam logic [2:0] OP_XOR = 3'd7;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_out;
    logic [2:0]       r_ctrl;
    logic [KW-1:0]    r_k;
    logic             r_carry;
    logic             r_busy;
    logic             r_done;
    logic             r_ovf;

    // Operands are shifted right each RUN cycle, so the current bit is always at index 0.
    logic             w_a;
    logic             w_b;
    logic             w_b_arith;
    logic             w_arith;
    logic             w_sum;
    logic             w_cout;
    logic             w_bit;
    logic [WIDTH-1:0] w_res_next;

    assign w_a        = r_a[0];
    assign w_b        = r_b[0];
    assign w_arith    = (r_ctrl == OP_ADD) || (r_ctrl == OP_SUB);
    assign w_b_arith  = w_b ^ (r_ctrl == OP_SUB);
    assign w_sum      = w_a ^ w_b_arith ^ r_carry;
    assign w_cout     = (w_a & w_b_arith) | (r_carry & (w_a ^ w_b_arith));
    assign w_res_next = {w_bit, r_res[WIDTH-1:1]};

    always_comb begin
        w_bit = 1'b0;
        case (r_ctrl)
            OP_ADD, OP_SUB: w_bit = w_sum;
            OP_AND:         w_bit = w_a & w_b;
            OP_OR:          w_bit = w_a | w_b;
            OP_NOR:         w_bit = ~(w_a | w_b);
            OP_XOR:         w_bit = w_a ^ w_b;
            default:        w_bit = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_out   <= '0;
            r_ctrl  <= '0;
            r_k     <= '0;
            r_carry <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_ctrl  <= control;
                        r_k     <= '0;
                        r_carry <= (control == OP_SUB);
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_res   <= w_res_next;
                    r_carry <= w_cout;
                    r_k     <= r_k + KW'(1);
                    if (r_k == K_LAST) begin
                        // At the MSB, r_carry is the carry into the sign bit.
                        r_out   <= w_res_next;
                        r_ovf   <= w_arith & (r_carry ^ w_cout);
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign out      = r_out;
    assign overflow = r_ovf;
    assign zero     = (r_out == '0);
    assign negative = r_out[WIDTH-1];

endmodule

// File: tb/tb_alu_serial.sv
// Randomized and directed bench for alu_serial at WIDTH=8 and WIDTH=32 against an arithmetic model.
module tb_alu_serial;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [2:0]  ctrl8 = '0;
    logic        busy8, done8, zero8, neg8, ovf8;
    logic [7:0]  out8;

    logic        start32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic [2:0]  ctrl32 = '0;
    logic        busy32, done32, zero32, neg32, ovf32;
    logic [31:0] out32;

    alu_serial #(.WIDTH(8)) dut8 (
        .clock(clk), .reset(rst), .start(start8), .A(a8), .B(b8), .control(ctrl8),
        .busy(busy8), .done(done8), .out(out8), .zero(zero8), .negative(neg8), .overflow(ovf8)
    );

    alu_serial #(.WIDTH(32)) dut32 (
        .clock(clk), .reset(rst), .start(start32), .A(a32), .B(b32), .control(ctrl32),
        .busy(busy32), .done(done32), .out(out32), .zero(zero32), .negative(neg32), .overflow(ovf32)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference: whole-word two's-complement arithmetic, overflow by the sign rule.
    function automatic void model(input int w, input logic [63:0] a_in, input logic [63:0] b_in,
                                  input logic [2:0] c, output logic [63:0] r, output logic ovf);
        logic [63:0] mask;
        logic [63:0] a;
        logic [63:0] b;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        a    = a_in & mask;
        b    = b_in & mask;
        ovf  = 1'b0;
        case (c)
            3'd2: begin
                r   = (a + b) & mask;
                ovf = (a[w-1] == b[w-1]) && (r[w-1] != a[w-1]);
            end
            3'd3: begin
                r   = (a - b) & mask;
                ovf = (a[w-1] != b[w-1]) && (r[w-1] != a[w-1]);
            end
            3'd4:    r = a & b;
            3'd5:    r = a | b;
            3'd6:    r = ~(a | b) & mask;
            3'd7:    r = a ^ b;
            default: r = '0;
        endcase
    endfunction

    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] c, input int glitch_at);
        logic [63:0] er;
        logic        eo;
        int          cycles;
        int          busy_cnt;
        model(8, {56'd0, a}, {56'd0, b}, c, er, eo);
        @(negedge clk);
        start8 = 1'b1; a8 = a; b8 = b; ctrl8 = c;
        @(negedge clk);
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); ctrl8 = 3'($urandom);
        cycles = 1; busy_cnt = 0;
        while (!done8 && cycles < 40) begin
            busy_cnt += int'(busy8);
            if (cycles == glitch_at) begin
                start8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom);
            end else begin
                start8 = 1'b0;
            end
            @(negedge clk);
            cycles++;
        end
        start8 = 1'b0;
        $display("op8 %s A=%02h B=%02h ctrl=%0d -> out=%02h z=%b n=%b v=%b after %0d cycles (model %02h v=%b)",
                 tag, a, b, c, out8, zero8, neg8, ovf8, cycles, er[7:0], eo);
        check({tag, "/done"},    64'(done8), 64'd1);
        check({tag, "/latency"}, 64'(cycles), 64'd9);
        check({tag, "/busycnt"}, 64'(busy_cnt), 64'd8);
        check({tag, "/busy"},    64'(busy8), 64'd0);
        check({tag, "/out"},     64'(out8), er);
        check({tag, "/zero"},    64'(zero8), 64'(er == 64'd0));
        check({tag, "/neg"},     64'(neg8), 64'(er[7]));
        check({tag, "/ovf"},     64'(ovf8), 64'(eo));
        @(negedge clk);
        check({tag, "/pulse"},   64'(done8), 64'd0);
        check({tag, "/hold"},    64'(out8), er);
    endtask

    task automatic run32(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] c);
        logic [63:0] er;
        logic        eo;
        int          cycles;
        model(32, {32'd0, a}, {32'd0, b}, c, er, eo);
        @(negedge clk);
        start32 = 1'b1; a32 = a; b32 = b; ctrl32 = c;
        @(negedge clk);
        start32 = 1'b0; a32 = $urandom; b32 = $urandom;
        cycles = 1;
        while (!done32 && cycles < 80) begin
            @(negedge clk);
            cycles++;
        end
        $display("op32 %s A=%08h B=%08h ctrl=%0d -> out=%08h z=%b n=%b v=%b after %0d cycles",
                 tag, a, b, c, out32, zero32, neg32, ovf32, cycles);
        check({tag, "/done"},    64'(done32), 64'd1);
        check({tag, "/latency"}, 64'(cycles), 64'd33);
        check({tag, "/out"},     64'(out32), er);
        check({tag, "/zero"},    64'(zero32), 64'(er == 64'd0));
        check({tag, "/neg"},     64'(neg32), 64'(er[31]));
        check({tag, "/ovf"},     64'(ovf32), 64'(eo));
    endtask

    task automatic quiet8(input string tag, input int n);
        int dones;
        dones = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            dones += int'(done8);
        end
        check({tag, "/nodone"}, 64'(dones), 64'd0);
        check({tag, "/idle"},   64'(busy8), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] er;
        logic        eo;
        int          cycles;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst/busy8", 64'(busy8), 64'd0);
        check("rst/done8", 64'(done8), 64'd0);
        check("rst/out8",  64'(out8),  64'd0);
        check("rst/zero8", 64'(zero8), 64'd1);
        check("rst/neg8",  64'(neg8),  64'd0);
        check("rst/ovf8",  64'(ovf8),  64'd0);
        check("rst/out32", 64'(out32), 64'd0);
        check("rst/zero32", 64'(zero32), 64'd1);

        run8("add_5_3",   8'h05, 8'h03, 3'd2, 0);
        run8("sub_80_01", 8'h80, 8'h01, 3'd3, 0);
        run8("add_7f_01", 8'h7F, 8'h01, 3'd2, 0);
        run8("sub_3_3",   8'h03, 8'h03, 3'd3, 0);
        run8("and",       8'hCA, 8'h5C, 3'd4, 0);
        run8("or",        8'hCA, 8'h5C, 3'd5, 0);
        run8("nor",       8'hCA, 8'h5C, 3'd6, 0);
        run8("xor",       8'hCA, 8'h5C, 3'd7, 0);
        run8("rsv0",      8'hCA, 8'h5C, 3'd0, 0);
        run8("rsv1",      8'hFF, 8'hFF, 3'd1, 0);

        // A start pulsed mid-RUN must not disturb the result or relaunch.
        run8("glitch", 8'h12, 8'h34, 3'd2, 3);
        quiet8("glitch", 12);

        // Reset four cycles into a RUN, with start also held during reset.
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h10; b8 = 8'h20; ctrl8 = 3'd2;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst/busy_before", 64'(busy8), 64'd1);
        rst = 1'b1; start8 = 1'b1;
        @(negedge clk);
        rst = 1'b0; start8 = 1'b0;
        $display("reset mid-run: busy=%b done=%b out=%02h zero=%b", busy8, done8, out8, zero8);
        check("midrst/busy", 64'(busy8), 64'd0);
        check("midrst/done", 64'(done8), 64'd0);
        check("midrst/out",  64'(out8),  64'd0);
        check("midrst/zero", 64'(zero8), 64'd1);
        check("midrst/neg",  64'(neg8),  64'd0);
        check("midrst/ovf",  64'(ovf8),  64'd0);
        quiet8("midrst", 12);
        run8("after_rst", 8'h01, 8'h01, 3'd2, 0);

        // start held high: each done cycle relaunches the next operation.
        @(negedge clk);
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'h01; ctrl8 = 3'd2;
        @(negedge clk);
        a8 = 8'h00; b8 = 8'h01; ctrl8 = 3'd3;
        cycles = 1;
        while (!done8 && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        model(8, 64'hFF, 64'h01, 3'd2, er, eo);
        $display("b2b first: out=%02h z=%b v=%b after %0d cycles", out8, zero8, ovf8, cycles);
        check("b2b1/done",    64'(done8), 64'd1);
        check("b2b1/latency", 64'(cycles), 64'd9);
        check("b2b1/out",     64'(out8), er);
        check("b2b1/zero",    64'(zero8), 64'(er == 64'd0));
        check("b2b1/ovf",     64'(ovf8), 64'(eo));
        @(negedge clk);
        cycles = 1;
        while (!done8 && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        start8 = 1'b0;
        model(8, 64'h00, 64'h01, 3'd3, er, eo);
        $display("b2b second: out=%02h n=%b v=%b after %0d more cycles", out8, neg8, ovf8, cycles);
        check("b2b2/done",    64'(done8), 64'd1);
        check("b2b2/spacing", 64'(cycles), 64'd9);
        check("b2b2/out",     64'(out8), er);
        check("b2b2/neg",     64'(neg8), 64'(er[7]));
        check("b2b2/ovf",     64'(ovf8), 64'(eo));
        quiet8("b2b", 12);

        for (int i = 0; i < 20; i++) begin
            run8($sformatf("rnd%0d", i), 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), 0);
        end

        run32("w32_ffff_plus1", 32'hFFFF_FFFF, 32'h1, 3'd2);
        run32("w32_sub_min",    32'h8000_0000, 32'h1, 3'd3);
        for (int i = 0; i < 6; i++) begin
            run32($sformatf("w32rnd%0d", i), $urandom, $urandom, 3'($urandom_range(2, 7)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
